// File: rtl/conv_window_mac_if.sv
// Window/weight/pixel bus for conv_window_mac: window handshake, weight write port and
// the strobed result pixel.
interface conv_window_mac_if #(
  parameter int unsigned BITS        = 9,
  parameter int unsigned KERNEL_SIZE = 3
);
  localparam int unsigned NTAPS = KERNEL_SIZE * KERNEL_SIZE;
  localparam int unsigned AW    = (NTAPS > 1) ? $clog2(NTAPS) : 1;

  logic                  in_valid;
  logic [NTAPS*BITS-1:0] window_in;
  logic                  in_ready;
  logic                  weight_wr_en;
  logic [AW-1:0]         weight_addr;
  logic [BITS-1:0]       weight_data;
  logic [BITS-1:0]       pixel_out;
  logic                  out_valid;

  modport master (
    output in_valid, window_in, weight_wr_en, weight_addr, weight_data,
    input  in_ready, pixel_out, out_valid
  );

  modport slave (
    input  in_valid, window_in, weight_wr_en, weight_addr, weight_data,
    output in_ready, pixel_out, out_valid
  );
endinterface

// File: rtl/conv_window_mac.sv
// Window convolution stage: captures a KERNEL_SIZE^2 window, runs one tap per clock through a
// single multiplier, then emits one shifted, saturated pixel.
module conv_window_mac #(
  parameter int unsigned BITS        = 9,
  parameter int unsigned KERNEL_SIZE = 3,
  parameter int unsigned SHIFT       = 0
) (
  input logic               clk,
  input logic               reset,
  conv_window_mac_if.slave  bus
);
  localparam int unsigned NTAPS = KERNEL_SIZE * KERNEL_SIZE;
  localparam int unsigned AW    = (NTAPS > 1) ? $clog2(NTAPS) : 1;
  localparam int unsigned PW    = 2 * BITS;
  localparam int unsigned ACCW  = PW + $clog2(NTAPS);
  localparam int          MaxInt = (1 << (BITS - 1)) - 1;
  localparam int          MinInt = -(1 << (BITS - 1));
  localparam logic signed [ACCW-1:0] MaxV = ACCW'(MaxInt);
  localparam logic signed [ACCW-1:0] MinV = ACCW'(MinInt);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StAccum = 2'd1;
  localparam logic [1:0] StDone  = 2'd2;

  logic [1:0]             state_q, state_d;
  logic [AW-1:0]          idx_q, idx_d;
  logic signed [ACCW-1:0] acc_q, acc_d;
  logic signed [BITS-1:0] win_q [NTAPS];
  logic signed [BITS-1:0] win_d [NTAPS];
  logic signed [BITS-1:0] wt_q  [NTAPS];
  logic signed [BITS-1:0] wt_d  [NTAPS];
  logic signed [BITS-1:0] pix_q, pix_d;
  logic                   ov_q, ov_d;

  logic signed [PW-1:0]   pix_x, wt_x, prod;
  logic signed [ACCW-1:0] prod_x, sum, shifted;
  logic signed [BITS-1:0] sat;

  // Single shared multiplier; operands sign-extended so the product is exact.
  always_comb begin
    pix_x   = PW'(win_q[idx_q]);
    wt_x    = PW'(wt_q[idx_q]);
    prod    = pix_x * wt_x;
    prod_x  = ACCW'(prod);
    sum     = acc_q + prod_x;
    shifted = sum >>> SHIFT;
    if (shifted > MaxV) begin
      sat = MaxV[BITS-1:0];
    end else if (shifted < MinV) begin
      sat = MinV[BITS-1:0];
    end else begin
      sat = shifted[BITS-1:0];
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    win_d   = win_q;
    wt_d    = wt_q;
    pix_d   = pix_q;
    ov_d    = 1'b0;

    if (state_q == StIdle && bus.weight_wr_en && 32'(bus.weight_addr) < NTAPS) begin
      wt_d[bus.weight_addr] = bus.weight_data;
    end

    case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          for (int j = 0; j < NTAPS; j++) begin
            win_d[j] = bus.window_in[BITS*j +: BITS];
          end
          acc_d   = '0;
          idx_d   = '0;
          state_d = StAccum;
        end
      end
      StAccum: begin
        acc_d = sum;
        idx_d = idx_q + AW'(1);
        if (idx_q == AW'(NTAPS - 1)) begin
          pix_d   = sat;
          ov_d    = 1'b1;
          idx_d   = '0;
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      idx_q   <= '0;
      acc_q   <= '0;
      win_q   <= '{default: '0};
      wt_q    <= '{default: '0};
      pix_q   <= '0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      win_q   <= win_d;
      wt_q    <= wt_d;
      pix_q   <= pix_d;
      ov_q    <= ov_d;
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.pixel_out = pix_q;
  assign bus.out_valid = ov_q;
endmodule

// File: tb/tb_conv_window_mac.sv
// Bench for conv_window_mac: SHIFT=0 and SHIFT=4 instances share stimulus and are checked
// against an arithmetic model of the window sum.
module tb_conv_window_mac;
  localparam int BITS  = 9;
  localparam int KS    = 3;
  localparam int NTAPS = KS * KS;
  localparam int AW    = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  conv_window_mac_if #(.BITS(BITS), .KERNEL_SIZE(KS)) if0 ();
  conv_window_mac_if #(.BITS(BITS), .KERNEL_SIZE(KS)) if4 ();

  conv_window_mac #(.BITS(BITS), .KERNEL_SIZE(KS), .SHIFT(0)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (if0.slave)
  );

  conv_window_mac #(.BITS(BITS), .KERNEL_SIZE(KS), .SHIFT(4)) dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (if4.slave)
  );

  assign if4.in_valid     = if0.in_valid;
  assign if4.window_in    = if0.window_in;
  assign if4.weight_wr_en = if0.weight_wr_en;
  assign if4.weight_addr  = if0.weight_addr;
  assign if4.weight_data  = if0.weight_data;

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int w_m [NTAPS];
  int t_m [NTAPS];

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int rnd_s();
    return int'($urandom_range(511, 0)) - 256;
  endfunction

  // Reference: plain integer dot product, floor shift, clamp to the pixel range.
  function automatic int model(input int sh);
    int s;
    s = 0;
    for (int j = 0; j < NTAPS; j++) s += t_m[j] * w_m[j];
    s = s >>> sh;
    if (s > 255) s = 255;
    if (s < -256) s = -256;
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_window();
    for (int j = 0; j < NTAPS; j++) if0.window_in[BITS*j +: BITS] = BITS'(t_m[j]);
  endtask

  task automatic wr_weight(input int a, input int d);
    if0.weight_wr_en = 1'b1;
    if0.weight_addr  = AW'(a);
    if0.weight_data  = BITS'(d);
    tick();
    if0.weight_wr_en = 1'b0;
    if (a < NTAPS) w_m[a] = d;
  endtask

  task automatic set_all_w(input int d);
    for (int j = 0; j < NTAPS; j++) wr_weight(j, d);
  endtask

  task automatic rand_w();
    for (int j = 0; j < NTAPS; j++) wr_weight(j, rnd_s());
  endtask

  task automatic rand_t();
    for (int j = 0; j < NTAPS; j++) t_m[j] = rnd_s();
  endtask

  task automatic run_window(input string tag, input bit busy_poke, input bit wr_accept,
                            input int wa, input int wd);
    int nvalid;
    int e0;
    int e4;
    nvalid = 0;
    load_window();
    if0.in_valid = 1'b1;
    if (wr_accept) begin
      if0.weight_wr_en = 1'b1;
      if0.weight_addr  = AW'(wa);
      if0.weight_data  = BITS'(wd);
    end
    tick();
    if0.in_valid     = 1'b0;
    if0.weight_wr_en = 1'b0;
    if (wr_accept && wa < NTAPS) w_m[wa] = wd;
    e0 = model(0);
    e4 = model(4);
    chk({tag, ".busy"}, 32'(if0.in_ready), 0);
    for (int k = 1; k <= NTAPS; k++) begin
      if (busy_poke && k == 3) begin
        if0.window_in    = ~if0.window_in;
        if0.in_valid     = 1'b1;
        if0.weight_wr_en = 1'b1;
        if0.weight_addr  = '0;
        if0.weight_data  = BITS'(w_m[0] + 1);
      end
      tick();
      if0.in_valid     = 1'b0;
      if0.weight_wr_en = 1'b0;
      if (if0.out_valid === 1'b1) nvalid++;
    end
    chk({tag, ".ov"}, 32'(if0.out_valid), 1);
    chk({tag, ".pix0"}, $signed(if0.pixel_out), e0);
    chk({tag, ".pix4"}, $signed(if4.pixel_out), e4);
    tick();
    chk({tag, ".ov_cnt"}, nvalid, 1);
    chk({tag, ".ov_clr"}, 32'(if0.out_valid), 0);
    chk({tag, ".rdy"}, 32'(if0.in_ready), 1);
    chk({tag, ".hold"}, $signed(if0.pixel_out), e0);
  endtask

  initial begin
    int nvalid;
    if0.in_valid     = 1'b0;
    if0.window_in    = '0;
    if0.weight_wr_en = 1'b0;
    if0.weight_addr  = '0;
    if0.weight_data  = '0;
    for (int j = 0; j < NTAPS; j++) w_m[j] = 0;
    #2;
    chk("rst.rdy", 32'(if0.in_ready), 1);
    chk("rst.ov", 32'(if0.out_valid), 0);
    chk("rst.pix", $signed(if0.pixel_out), 0);
    tick();
    reset = 1'b0;
    tick();
    chk("idle.rdy", 32'(if0.in_ready), 1);

    rand_t();
    run_window("zero_w", 1'b0, 1'b0, 0, 0);

    set_all_w(1);
    for (int j = 0; j < NTAPS; j++) t_m[j] = j;
    run_window("ones", 1'b0, 1'b0, 0, 0);

    set_all_w(-1);
    wr_weight(4, 8);
    for (int j = 0; j < NTAPS; j++) t_m[j] = 7;
    run_window("lap_flat", 1'b0, 1'b0, 0, 0);
    t_m[4] = 20;
    run_window("lap_peak", 1'b0, 1'b0, 0, 0);

    set_all_w(255);
    for (int j = 0; j < NTAPS; j++) t_m[j] = 255;
    run_window("sat_hi", 1'b0, 1'b0, 0, 0);
    for (int j = 0; j < NTAPS; j++) t_m[j] = -256;
    run_window("sat_lo", 1'b0, 1'b0, 0, 0);

    rand_w();
    rand_t();
    run_window("busy", 1'b1, 1'b0, 0, 0);
    rand_t();
    run_window("after_busy", 1'b0, 1'b0, 0, 0);

    wr_weight(12, 5);
    rand_t();
    run_window("bad_addr", 1'b0, 1'b0, 0, 0);

    rand_t();
    run_window("wr_accept", 1'b0, 1'b1, int'($urandom_range(NTAPS - 1, 0)), rnd_s());

    for (int r = 0; r < 6; r++) begin
      rand_w();
      rand_t();
      run_window("rand", 1'b0, 1'b0, 0, 0);
    end

    set_all_w(3);
    rand_t();
    load_window();
    if0.in_valid = 1'b1;
    tick();
    if0.in_valid = 1'b0;
    for (int k = 1; k <= 4; k++) tick();
    reset = 1'b1;
    #1;
    chk("abort.rdy", 32'(if0.in_ready), 1);
    chk("abort.ov", 32'(if0.out_valid), 0);
    chk("abort.pix", $signed(if0.pixel_out), 0);
    tick();
    reset = 1'b0;
    for (int j = 0; j < NTAPS; j++) w_m[j] = 0;
    nvalid = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (if0.out_valid !== 1'b0) nvalid++;
    end
    chk("abort.no_ov", nvalid, 0);
    rand_t();
    run_window("abort.zero_w", 1'b0, 1'b0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
